// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin bus arbiter with watchdog and decode-error release
module bus_arbiter_rr #(
  parameter int masters = 2,
  parameter int timeout = 256
) (
  input  logic               CLK,
  input  logic               RESETn,
  input  logic [masters-1:0] REQUESTS,
  input  logic               LAST,
  input  logic               SELECT_ERROR,
  output logic [masters-1:0] BUS_GRANTS,
  output logic               BUS_BUSY,
  output logic               TIMEOUT,
  output logic               SELECT_ABORT
);
  localparam int pw = $clog2(masters);
  localparam int cw = $clog2(timeout);
  localparam logic [pw:0] M = (pw + 1)'(masters);
  localparam logic [cw-1:0] TMAX = cw'(timeout - 1);
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  state_t state, state_n;
  logic [pw-1:0] owner, owner_n, pointer, pointer_n, winner;
  logic [cw-1:0] count, count_n;
  logic [masters-1:0] rot;
  logic [pw:0] k, sum;
  logic exit;
  // requests rotated so bit 0 is the pointer position; lowest set bit wins
  always_comb begin
    rot = masters'({REQUESTS, REQUESTS} >> pointer);
    k = '0;
    for (int i = masters - 1; i >= 0; i--) if (rot[i]) k = (pw + 1)'(i);
    sum = {1'b0, pointer} + k;
    winner = pw'(sum >= M ? sum - M : sum);
  end
  always_comb begin
    exit = SELECT_ERROR || count == TMAX || LAST || !REQUESTS[owner];
    state_n = state;
    owner_n = owner;
    pointer_n = pointer;
    count_n = count;
    if (state == GRANT) begin
      state_n = exit ? RELEASE : GRANT;
      count_n = exit ? count : count + 1'b1;
    end else if (|REQUESTS) begin
      state_n = GRANT;
      owner_n = winner;
      pointer_n = {1'b0, winner} == M - 1'b1 ? '0 : winner + 1'b1;
      count_n = '0;
    end else state_n = IDLE;
  end
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= IDLE;
      owner <= '0;
      pointer <= '0;
      count <= '0;
      BUS_GRANTS <= '0;
      BUS_BUSY <= 1'b0;
      TIMEOUT <= 1'b0;
      SELECT_ABORT <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      pointer <= pointer_n;
      count <= count_n;
      BUS_GRANTS <= state_n == GRANT ? {{(masters - 1){1'b0}}, 1'b1} << owner_n : '0;
      BUS_BUSY <= state_n == GRANT;
      TIMEOUT <= state == GRANT && count == TMAX && !SELECT_ERROR;
      SELECT_ABORT <= state == GRANT && SELECT_ERROR;
    end
  end
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: scoreboard bench with a cycle-level reference model of the arbiter
module tb_bus_arbiter_rr;
  localparam int M = 4;
  localparam int T = 8;
  logic CLK = 0, RESETn = 1, LAST = 0, SELECT_ERROR = 0;
  logic [M-1:0] REQUESTS = '0, BUS_GRANTS;
  logic BUS_BUSY, TIMEOUT, SELECT_ABORT;
  logic [M+2:0] exp_q[$];
  int checks = 0, errors = 0;
  int m_own = -1, m_hold = 0, m_ptr = 0;
  always #5 CLK = ~CLK;
  bus_arbiter_rr #(.masters(M), .timeout(T)) dut (
    .CLK(CLK), .RESETn(RESETn), .REQUESTS(REQUESTS), .LAST(LAST),
    .SELECT_ERROR(SELECT_ERROR), .BUS_GRANTS(BUS_GRANTS), .BUS_BUSY(BUS_BUSY),
    .TIMEOUT(TIMEOUT), .SELECT_ABORT(SELECT_ABORT)
  );
  // m_hold counts granted cycles seen so far by the current owner
  task automatic model(input logic [M-1:0] req, input logic last, input logic se);
    logic [M-1:0] g = '0;
    logic to = 0, ab = 0;
    if (m_own >= 0) begin
      if (se || m_hold == T || last || !req[m_own]) begin
        to = !se && m_hold == T;
        ab = se;
        m_own = -1;
      end else m_hold++;
    end else
      for (int k = 0; k < M; k++)
        if (m_own < 0 && req[(m_ptr + k) % M]) begin
          m_own = (m_ptr + k) % M;
          m_ptr = (m_own + 1) % M;
          m_hold = 1;
        end
    if (m_own >= 0) g[m_own] = 1'b1;
    exp_q.push_back({g, m_own >= 0, to, ab});
  endtask
  task automatic cyc(input logic [M-1:0] req, input logic last, input logic se);
    @(negedge CLK);
    RESETn = 1;
    REQUESTS = req;
    LAST = last;
    SELECT_ERROR = se;
    model(req, last, se);
  endtask
  task automatic rst();
    @(negedge CLK);
    RESETn = 0;
    #1;
    checks++;
    if (BUS_GRANTS !== '0 || BUS_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL async_reset grants=%b busy=%b want 0 0", BUS_GRANTS, BUS_BUSY);
    end
    m_own = -1;
    m_ptr = 0;
    m_hold = 0;
    exp_q.push_back('0);
  endtask
  initial begin
    logic [M+2:0] e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({BUS_GRANTS, BUS_BUSY, TIMEOUT, SELECT_ABORT} !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got g=%b busy=%b to=%b ab=%b want g=%b busy=%b to=%b ab=%b",
                   $time, BUS_GRANTS, BUS_BUSY, TIMEOUT, SELECT_ABORT, e[M+2:3], e[2], e[1], e[0]);
        end
      end
    end
  end
  initial begin
    logic [M-1:0] r;
    r = '0;
    REQUESTS = 4'hF;
    repeat (3) rst();
    cyc(4'hF, 0, 0);
    repeat (24) cyc(4'hF, m_own >= 0 && m_hold == 3, 0);
    repeat (24) cyc(4'h2, 0, 0);
    repeat (30) cyc(4'h3, 0, m_own == 0 && m_hold == T);
    repeat (3) cyc(4'h1, 0, 0);
    repeat (6) cyc(4'h0, 0, 0);
    repeat (3) cyc(4'hF, 0, 0);
    rst();
    repeat (3) cyc(4'h3, 0, 0);
    repeat (3000) begin
      r = r ^ M'($urandom() & $urandom());
      if ($urandom_range(0, 299) == 0) rst();
      else cyc(r, $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0);
    end
    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
